// File: rtl/reg_file_write_decoder.sv
// ============================================================================
// Module   : reg_file_write_decoder
// Purpose  : 8-entry register file with a one-hot write decoder, two async reads
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_write_decoder #(
  parameter int WIDTH    = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             write_enable_i,
  input  logic [2:0]       write_addr_i,
  input  logic [WIDTH-1:0] write_data_i,
  input  logic [2:0]       read_addr1_i,
  input  logic [2:0]       read_addr2_i,
  output logic [WIDTH-1:0] read_data1_o,
  output logic [WIDTH-1:0] read_data2_o,
  output logic [7:0]       write_onehot_o,
  output logic [7:0]       write_count_o
);

  localparam logic [7:0] ACCEPT_MASK = ZERO_REG ? 8'hFE : 8'hFF;

  logic [WIDTH-1:0] regs_q [8];
  logic [7:0]       strobe;
  logic [7:0]       wr_mask;
  logic [7:0]       write_onehot_q, write_onehot_d;
  logic [7:0]       write_count_q,  write_count_d;

  // Enable gates every bit, so an unknown address with enable low strobes nothing.
  always_comb begin
    strobe = 8'h00;
    for (int i = 0; i < 8; i++) begin
      strobe[i] = write_enable_i && (write_addr_i == 3'(i));
    end
  end

  assign wr_mask        = strobe & ACCEPT_MASK;
  assign write_onehot_d = wr_mask;
  assign write_count_d  = write_count_q + {7'd0, |wr_mask};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
      write_onehot_q <= 8'h00;
      write_count_q  <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_mask[i]) begin
          regs_q[i] <= write_data_i;
        end
      end
      write_onehot_q <= write_onehot_d;
      write_count_q  <= write_count_d;
    end
  end

  // No write bypass: a same-cycle read sees the stored (old) value.
  assign read_data1_o   = regs_q[read_addr1_i];
  assign read_data2_o   = regs_q[read_addr2_i];
  assign write_onehot_o = write_onehot_q;
  assign write_count_o  = write_count_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_write_decoder.sv
// ============================================================================
// Module   : tb_reg_file_write_decoder
// Purpose  : Self-checking bench for reg_file_write_decoder (ZERO_REG=1 and 0)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_write_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [2:0]  wa, ra1, ra2;
  logic [31:0] wd;
  logic [31:0] z_rd1, z_rd2, n_rd1, n_rd2;
  logic [7:0]  z_oh, z_cnt, n_oh, n_cnt;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  reg_file_write_decoder #(.WIDTH(32), .ZERO_REG(1'b1)) dut_z (
    .clk_i(clk), .reset_i(reset), .write_enable_i(we), .write_addr_i(wa),
    .write_data_i(wd), .read_addr1_i(ra1), .read_addr2_i(ra2),
    .read_data1_o(z_rd1), .read_data2_o(z_rd2),
    .write_onehot_o(z_oh), .write_count_o(z_cnt)
  );

  reg_file_write_decoder #(.WIDTH(32), .ZERO_REG(1'b0)) dut_n (
    .clk_i(clk), .reset_i(reset), .write_enable_i(we), .write_addr_i(wa),
    .write_data_i(wd), .read_addr1_i(ra1), .read_addr2_i(ra2),
    .read_data1_o(n_rd1), .read_data2_o(n_rd2),
    .write_onehot_o(n_oh), .write_count_o(n_cnt)
  );

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [7:0]  eoh;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t vecs [11];

  // Reference state: plain arrays updated from the architectural rules.
  logic [31:0] mz [8];
  logic [31:0] mn [8];
  logic [7:0]  moh_z, moh_n, mcnt_z, mcnt_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] a, input logic [31:0] d,
                       input logic [2:0] r1, input logic [2:0] r2);
    we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic model_write(input logic w, input logic [2:0] a, input logic [31:0] d);
    if (w) begin
      mn[a]  = d;
      moh_n  = 8'd1 << a;
      mcnt_n = mcnt_n + 8'd1;
      if (a != 3'd0) begin
        mz[a]  = d;
        moh_z  = 8'd1 << a;
        mcnt_z = mcnt_z + 8'd1;
      end else begin
        moh_z = 8'h00;
      end
    end else begin
      moh_z = 8'h00;
      moh_n = 8'h00;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd0);

    // Vectors from the reset state: expectations are pre-edge reads and post-edge flags.
    vecs[0] = '{1'b1, 3'd5, 32'hDEADBEEF, 3'd5, 3'd0, 32'h0, 32'h0, 8'h20, 8'd1};
    vecs[1] = '{1'b0, 3'd0, 32'h0, 3'd5, 3'd5, 32'hDEADBEEF, 32'hDEADBEEF, 8'h00, 8'd1};
    vecs[2] = '{1'b1, 3'd1, 32'h11, 3'd1, 3'd5, 32'h0, 32'hDEADBEEF, 8'h02, 8'd2};
    vecs[3] = '{1'b1, 3'd2, 32'h22, 3'd2, 3'd1, 32'h0, 32'h11, 8'h04, 8'd3};
    vecs[4] = '{1'b1, 3'd3, 32'h33, 3'd3, 3'd2, 32'h0, 32'h22, 8'h08, 8'd4};
    vecs[5] = '{1'b1, 3'd4, 32'h44, 3'd4, 3'd3, 32'h0, 32'h33, 8'h10, 8'd5};
    vecs[6] = '{1'b1, 3'd5, 32'h55, 3'd5, 3'd4, 32'hDEADBEEF, 32'h44, 8'h20, 8'd6};
    vecs[7] = '{1'b1, 3'd6, 32'h66, 3'd6, 3'd5, 32'h0, 32'h55, 8'h40, 8'd7};
    vecs[8] = '{1'b1, 3'd7, 32'h77, 3'd7, 3'd6, 32'h0, 32'h66, 8'h80, 8'd8};
    vecs[9] = '{1'b0, 3'd3, 32'hFFFFFFFF, 3'd3, 3'd7, 32'h33, 32'h77, 8'h00, 8'd8};
    vecs[10] = '{1'b0, 3'd0, 32'h0, 3'd3, 3'd7, 32'h33, 32'h77, 8'h00, 8'd8};

    // Reset state
    #2;
    chk("rst_rd1", z_rd1, 32'h0);
    chk("rst_oh", z_oh, 8'h00);
    chk("rst_cnt", z_cnt, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_oh", z_oh, 8'h00);
    chk("post_rst_cnt", n_cnt, 8'h00);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
      #3;
      chk($sformatf("vec%0d_z_rd1", i), z_rd1, vecs[i].e1);
      chk($sformatf("vec%0d_z_rd2", i), z_rd2, vecs[i].e2);
      chk($sformatf("vec%0d_n_rd1", i), n_rd1, vecs[i].e1);
      chk($sformatf("vec%0d_n_rd2", i), n_rd2, vecs[i].e2);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_z_oh", i), z_oh, vecs[i].eoh);
      chk($sformatf("vec%0d_z_cnt", i), z_cnt, vecs[i].ecnt);
      chk($sformatf("vec%0d_n_oh", i), n_oh, vecs[i].eoh);
      chk($sformatf("vec%0d_n_cnt", i), n_cnt, vecs[i].ecnt);
    end

    // Register 0 write: ignored with ZERO_REG=1, stored with ZERO_REG=0
    drive(1'b1, 3'd0, 32'h12345678, 3'd0, 3'd0);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 32'h0, 3'd0, 3'd0);
    #1;
    chk("zr_z_rd", z_rd1, 32'h0);
    chk("zr_z_oh", z_oh, 8'h00);
    chk("zr_z_cnt", z_cnt, 8'd8);
    chk("zr_n_rd", n_rd2, 32'h12345678);
    chk("zr_n_oh", n_oh, 8'h01);
    chk("zr_n_cnt", n_cnt, 8'd9);

    // Asynchronous reset between edges, with a write pending during reset
    @(posedge clk); #1;
    drive(1'b1, 3'd2, 32'hA5A5A5A5, 3'd2, 3'd2);
    @(posedge clk); #1;
    chk("ar_pre_rd", z_rd1, 32'hA5A5A5A5);
    drive(1'b1, 3'd4, 32'hCAFEF00D, 3'd2, 3'd4);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_z_rd", z_rd1, 32'h0);
    chk("ar_n_rd", n_rd1, 32'h0);
    chk("ar_z_cnt", z_cnt, 8'h00);
    chk("ar_n_oh", n_oh, 8'h00);
    @(posedge clk); #1;
    chk("ar_lost_wr", z_rd2, 32'h0);
    reset = 1'b0;
    drive(1'b1, 3'd6, 32'h0BADF00D, 3'd6, 3'd6);
    @(posedge clk); #1;
    chk("ar_first_rd", z_rd1, 32'h0BADF00D);
    chk("ar_first_cnt", z_cnt, 8'd1);
    chk("ar_first_oh", n_oh, 8'h40);

    // Counter wrap: 255 writes reach FF, the 256th wraps to 00
    do_reset();
    for (int k = 0; k < 255; k++) begin
      drive(1'b1, 3'((k % 7) + 1), 32'(k), 3'd0, 3'd0);
      @(posedge clk); #1;
    end
    chk("wrap_255_z", z_cnt, 8'hFF);
    chk("wrap_255_n", n_cnt, 8'hFF);
    drive(1'b1, 3'd3, 32'h1, 3'd0, 3'd0);
    @(posedge clk); #1;
    chk("wrap_256_z", z_cnt, 8'h00);
    chk("wrap_256_n", n_cnt, 8'h00);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 8; i++) begin
      mz[i] = 32'h0;
      mn[i] = 32'h0;
    end
    moh_z = 8'h00; moh_n = 8'h00; mcnt_z = 8'h00; mcnt_n = 8'h00;
    for (int c = 0; c < 200; c++) begin
      logic w;
      w = 1'($urandom_range(0, 1));
      drive(w, 3'($urandom_range(0, 7)), $urandom, 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)));
      if (!w && (c % 5 == 0)) wa = 3'bxxx;
      #3;
      chk("rnd_z_rd1", z_rd1, mz[ra1]);
      chk("rnd_z_rd2", z_rd2, mz[ra2]);
      chk("rnd_n_rd1", n_rd1, mn[ra1]);
      chk("rnd_n_rd2", n_rd2, mn[ra2]);
      model_write(w, wa, wd);
      @(posedge clk); #1;
      chk("rnd_z_oh", z_oh, moh_z);
      chk("rnd_z_cnt", z_cnt, mcnt_z);
      chk("rnd_n_oh", n_oh, moh_n);
      chk("rnd_n_cnt", n_cnt, mcnt_n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
